// File: rtl/frog_game_core.sv
// Frogger playfield core: car rows, frog movement, collisions, lives, outcome.
// Ports: frame_clk/Reset, up/down/left/right keys; FrogX/FrogY, Car_X/Car_Y,
//        Car_Collision, dead_frog, frog_lives, win_game, lose_game.
module frog_game_core #(
    parameter int FROG_X_START = 320,
    parameter int NUM_CARS     = 4,
    parameter int GAP          = 80,
    parameter int SPEED [4]    = '{10, 7, 3, 1},
    parameter int DIR   [4]    = '{1, 0, 1, 0},
    parameter int ROW_Y [4]    = '{400, 360, 320, 280}
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    output logic [10:0]            FrogX,
    output logic [10:0]            FrogY,
    output logic [3:0][3:0][10:0]  Car_X,
    output logic [3:0][10:0]       Car_Y,
    output logic [3:0]             Car_Collision,
    output logic                   dead_frog,
    output logic [1:0]             frog_lives,
    output logic                   win_game,
    output logic                   lose_game
);

    localparam logic [10:0] START_X = 11'(FROG_X_START);
    localparam logic [10:0] START_Y = 11'd440;

    // Car rows: one wrapping base register per row, cars at fixed offsets.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam logic [10:0] SPD = 11'(SPEED[r]);
        localparam logic [10:0] RY  = 11'(ROW_Y[r]);

        logic [10:0] base;
        logic [10:0] inc;
        logic [10:0] dec;
        logic [10:0] nxt;
        logic [3:0]  hit;

        assign inc = base + SPD;
        assign dec = (base < SPD) ? base + 11'd640 - SPD : base - SPD;
        assign nxt = (DIR[r] != 0)
                   ? ((inc >= 11'd640) ? inc - 11'd640 : inc)
                   : dec;

        always_ff @(posedge frame_clk or negedge Reset) begin
            if (!Reset) base <= '0;
            else        base <= nxt;
        end

        for (genvar k = 0; k < 4; k++) begin : g_car
            if (k < NUM_CARS) begin : g_used
                localparam logic [10:0] OFS = 11'(k * (40 + GAP));
                logic [10:0] raw;
                logic [10:0] cx;
                assign raw = base + OFS;
                assign cx  = (raw >= 11'd640) ? raw - 11'd640 : raw;
                assign Car_X[r][k] = cx;
                // No wrap-side test: a car straddling X=640 only hits on-screen.
                assign hit[k] = (FrogX < cx + 11'd40) && (cx < FrogX + 11'd40);
            end else begin : g_unused
                assign Car_X[r][k] = '0;
                assign hit[k] = 1'b0;
            end
        end

        assign Car_Y[r]         = RY;
        assign Car_Collision[r] = (FrogY == RY) && (|hit);
    end

    // Keys packed {up, down, left, right}; bit order is also move priority.
    logic [3:0]  keys;
    logic [3:0]  key_prev;
    logic [3:0]  rise;
    logic [10:0] mv_x;
    logic [10:0] mv_y;
    logic        mv_ok;

    assign keys = {up, down, left, right};
    assign rise = keys & ~key_prev;

    always_comb begin
        mv_x  = FrogX;
        mv_y  = FrogY;
        mv_ok = 1'b0;
        priority case (1'b1)
            rise[3]: if (FrogY >= 11'd80) begin
                mv_y  = FrogY - 11'd40;
                mv_ok = 1'b1;
            end
            rise[2]: if (FrogY <= 11'd400) begin
                mv_y  = FrogY + 11'd40;
                mv_ok = 1'b1;
            end
            rise[1]: if (FrogX >= 11'd40) begin
                mv_x  = FrogX - 11'd40;
                mv_ok = 1'b1;
            end
            rise[0]: if (FrogX <= 11'd560) begin
                mv_x  = FrogX + 11'd40;
                mv_ok = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            key_prev   <= '0;
            FrogX      <= START_X;
            FrogY      <= START_Y;
            dead_frog  <= 1'b0;
            frog_lives <= 2'd3;
            win_game   <= 1'b0;
            lose_game  <= 1'b0;
        end else begin
            key_prev  <= keys;
            dead_frog <= 1'b0;
            if (!win_game && !lose_game) begin
                // A kill overrides any key move taken on the same edge.
                if (|Car_Collision) begin
                    dead_frog <= 1'b1;
                    FrogX     <= START_X;
                    FrogY     <= START_Y;
                    if (frog_lives != 2'd0)
                        frog_lives <= frog_lives - 2'd1;
                    if (frog_lives <= 2'd1)
                        lose_game <= 1'b1;
                end else if (mv_ok) begin
                    FrogX <= mv_x;
                    FrogY <= mv_y;
                    if (mv_y == 11'd40)
                        win_game <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frog_game_core.sv
// Directed self-checking bench for frog_game_core.
// Second instance with stopped cars covers the win path.
module tb_frog_game_core;

    logic frame_clk = 1'b0;
    logic rst_n = 1'b1;
    logic up = 0, down = 0, left = 0, right = 0;
    logic [10:0] frog_x, frog_y;
    logic [3:0][3:0][10:0] car_x;
    logic [3:0][10:0] car_y;
    logic [3:0] coll;
    logic dead, win, lose;
    logic [1:0] lives;

    logic w_up = 0, w_down = 0, w_left = 0, w_right = 0;
    logic [10:0] w_x, w_y;
    logic [3:0][3:0][10:0] w_car_x;
    logic [3:0][10:0] w_car_y;
    logic [3:0] w_coll;
    logic w_dead, w_win, w_lose;
    logic [1:0] w_lives;

    int total = 0;
    int passed = 0;
    int n = 0;

    always #5 frame_clk = ~frame_clk;

    frog_game_core dut (
        .frame_clk(frame_clk), .Reset(rst_n),
        .up(up), .down(down), .left(left), .right(right),
        .FrogX(frog_x), .FrogY(frog_y), .Car_X(car_x), .Car_Y(car_y),
        .Car_Collision(coll), .dead_frog(dead), .frog_lives(lives),
        .win_game(win), .lose_game(lose)
    );

    frog_game_core #(.SPEED('{0, 0, 0, 0})) dut_w (
        .frame_clk(frame_clk), .Reset(rst_n),
        .up(w_up), .down(w_down), .left(w_left), .right(w_right),
        .FrogX(w_x), .FrogY(w_y), .Car_X(w_car_x), .Car_Y(w_car_y),
        .Car_Collision(w_coll), .dead_frog(w_dead), .frog_lives(w_lives),
        .win_game(w_win), .lose_game(w_lose)
    );

    typedef struct {
        logic [3:0] keys;   // {up, down, left, right}
        int         ex;
        int         ey;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        n++;
        @(negedge frame_clk);
    endtask

    function automatic int exp_base(input int r, input int nn);
        int s [4] = '{10, 7, 3, 1};
        int d [4] = '{1, 0, 1, 0};
        int m;
        m = (s[r] * nn) % 640;
        return (d[r] != 0) ? m : (640 - m) % 640;
    endfunction

    task automatic check_cars(input string tag);
        int e;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                e = (exp_base(r, n) + k * 120) % 640;
                chk($sformatf("%s car_x[%0d][%0d]", tag, r, k),
                    car_x[r][k], e);
            end
    endtask

    task automatic pulse_left();
        left = 1; tick(); left = 0; tick();
    endtask

    task automatic pulse_right();
        right = 1; tick(); right = 0; tick();
    endtask

    initial begin
        int waited;
        tbl[0] = '{4'b0000, 320, 440};
        tbl[1] = '{4'b0010, 280, 440};
        tbl[2] = '{4'b0010, 280, 440};
        tbl[3] = '{4'b0000, 280, 440};
        tbl[4] = '{4'b0011, 240, 440};
        tbl[5] = '{4'b0000, 240, 440};
        tbl[6] = '{4'b0001, 280, 440};
        tbl[7] = '{4'b0000, 280, 440};
        tbl[8] = '{4'b0100, 280, 440};
        tbl[9] = '{4'b0000, 280, 440};

        // Reset state
        #1 rst_n = 0;
        #1;
        check_cars("reset");
        chk("reset frog_x", frog_x, 320);
        chk("reset frog_y", frog_y, 440);
        chk("reset lives", lives, 3);
        chk("reset flags", {dead, win, lose}, 0);
        chk("car_y row0", car_y[0], 400);
        chk("car_y row3", car_y[3], 280);
        @(negedge frame_clk);
        rst_n = 1;
        n = 0;
        tick();
        chk("edge1 row0 car0", car_x[0][0], 10);
        chk("edge1 row0 car3", car_x[0][3], 370);
        chk("edge1 row1 car0", car_x[1][0], 633);
        check_cars("edge1");

        // Horizontal moves on the safe spawn row
        for (int i = 0; i < 10; i++) begin
            {up, down, left, right} = tbl[i].keys;
            tick();
            chk($sformatf("vec%0d x", i), frog_x, tbl[i].ex);
            chk($sformatf("vec%0d y", i), frog_y, tbl[i].ey);
        end
        {up, down, left, right} = 4'b0000;
        for (int i = 0; i < 9; i++) pulse_left();
        chk("left bound x", frog_x, 0);
        for (int i = 0; i < 17; i++) pulse_right();
        chk("right bound x", frog_x, 600);
        check_cars("midgame");

        // Asynchronous mid-game reset
        rst_n = 0;
        #1;
        chk("async rst x", frog_x, 320);
        chk("async rst car0", car_x[0][0], 0);
        @(negedge frame_clk);
        rst_n = 1;
        n = 0;

        // Held up moves once; first collision and death timing
        up = 1;
        tick();
        chk("up once y", frog_y, 400);
        chk("n1 row0 car2", car_x[0][2], 250);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("held up y n%0d", i), frog_y, 400);
            chk($sformatf("no coll n%0d", i), coll, 0);
        end
        tick();
        chk("coll n5", coll, 4'b0001);
        chk("no dead yet", dead, 0);
        left = 1;
        tick();
        chk("death pulse", dead, 1);
        chk("respawn x no move", frog_x, 320);
        chk("respawn y", frog_y, 440);
        chk("lives 2", lives, 2);
        up = 0;
        left = 0;
        tick();
        chk("death pulse ends", dead, 0);
        chk("lives hold", lives, 2);

        // Two more deaths to game over
        for (int d = 2; d <= 3; d++) begin
            tick();
            up = 1;
            tick();
            up = 0;
            chk($sformatf("d%0d enter row0", d), frog_y, 400);
            waited = 0;
            while (!dead && waited < 200) begin
                tick();
                waited++;
            end
            chk($sformatf("d%0d death seen", d), dead, 1);
            chk($sformatf("d%0d lives", d), lives, 3 - d);
        end
        chk("lose flag", lose, 1);
        chk("win flag clear", win, 0);
        tick();
        up = 1;
        tick();
        up = 0;
        chk("frozen y", frog_y, 440);
        chk("frozen lives", lives, 0);
        chk("still lost", lose, 1);
        check_cars("after lose");

        // Win path on stopped cars; up+left same frame takes up only
        chk("w start y", w_y, 440);
        w_up = 1;
        w_left = 1;
        tick();
        w_up = 0;
        w_left = 0;
        chk("w priority x", w_x, 320);
        chk("w priority y", w_y, 400);
        tick();
        for (int i = 0; i < 8; i++) begin
            w_up = 1; tick(); w_up = 0; tick();
        end
        chk("w y80", w_y, 80);
        chk("w not won", w_win, 0);
        chk("w edge car no coll", w_coll, 0);
        w_up = 1;
        tick();
        w_up = 0;
        chk("w y40", w_y, 40);
        chk("w win", w_win, 1);
        tick();
        w_down = 1;
        tick();
        w_down = 0;
        chk("w frozen y", w_y, 40);
        chk("w lives", w_lives, 3);
        chk("w no lose", {w_dead, w_lose}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frog_game_core.md
# frog_game_core

Playfield core of the Frogger game: moves four rows of cars, moves one player frog from key presses, detects frog/car collisions, and tracks lives and the win/lose outcome. It advances once per video frame on `frame_clk` and feeds the sprite renderer with positions and game status. Lily pads and multi-frog selection are outside this block.

## Interface
- `FROG_X_START`, default 320: frog spawn X in pixels; spawn Y is fixed at 440.
- `NUM_CARS`, default 4: cars per row, 1..4.
- `GAP`, default 80: pixel gap between adjacent cars in a row.
- `SPEED`, default {10,7,3,1}: pixels moved per frame, rows 0..3.
- `DIR`, default {1,0,1,0}: direction per row; 1 = +X (rightward), 0 = −X.
- `ROW_Y`, default {400,360,320,280}: Y coordinate of each row.
- `frame_clk  in  1`: single clock, one rising edge per frame.
- `Reset  in  1`: asynchronous, active-low reset.
- `up`, `down`, `left`, `right  in  1 each`: level key inputs.
- `FrogX`, `FrogY  out  11 each`: frog top-left position.
- `Car_X  out  4×4×11`: per row, per car top-left X; unused cars (index ≥ NUM_CARS) output 0.
- `Car_Y  out  4×11`: per-row Y, equal to `ROW_Y`.
- `Car_Collision  out  4`: bit r is high while the frog overlaps any car in row r.
- `dead_frog  out  1`: one-frame pulse when the frog is killed.
- `frog_lives  out  2`: remaining lives.
- `win_game`, `lose_game  out  1 each`: sticky outcome flags.

## Operation
- Playfield: 640×480. Frog and cars are 40×40. Frog X is in [0,600] and Y in [40,440], on a 40-px grid.
- Each row has a base register `B`, 0..639:
  - DIR=1: `B ← B+SPEED`; if the result is ≥640, subtract 640.
  - DIR=0: if `B < SPEED`, `B ← B+640−SPEED`; otherwise `B ← B−SPEED`.
- Car k X = `(B + k·(40+GAP)) mod 640`. Use 11-bit arithmetic with a single conditional subtract.
- Collision is combinational from registered values. `Car_Collision[r]` = (FrogY == ROW_Y[r]) and, for some car k < NUM_CARS, (FrogX < CarX+40) and (CarX < FrogX+40).
  - A car straddling X=640 collides only on its on-screen part; there is no wrap-side collision.
- Key handling:
  - Each key is rising-edge detected against its value registered on the previous frame. A held key moves the frog once.
  - A move is one step of 40 px. Priority when several keys rise in the same frame: up > down > left > right.
  - A move that would leave the bounds is ignored.
  - Up decreases Y.
- Death: if any `Car_Collision` bit is high at a frame edge:
  - `dead_frog` is 1 for that next frame.
  - The frog respawns at (FROG_X_START, 440).
  - `frog_lives` decrements.
  - Any key move in that same frame is discarded.
- `frog_lives` reaching 0 sets `lose_game`. Lives never go below 0.
- An accepted move that lands at FrogY=40 sets `win_game` on the same edge.
- Once `win_game` or `lose_game` is set:
  - The frog freezes and ignores keys.
  - No further deaths are counted.
  - Cars keep moving.
  - Only reset clears the flags.

## Timing
- All state updates on the rising edge of `frame_clk`. Reset is asynchronous active-low; outputs take reset values immediately.
- Reset values:
  - All `B`=0, so row car X = 0, 120, 240, 360.
  - FrogX=FROG_X_START, FrogY=440.
  - frog_lives=3, dead_frog=0, win_game=0, lose_game=0.
  - Key history = 0.
- Latency:
  - A key rise sampled at edge n gives the new position after edge n.
  - A collision visible after edge n gives `dead_frog`, respawn and decrement after edge n+1.
  - `dead_frog` lasts exactly one frame. The spawn row Y=440 holds no cars, so there is no repeated death.
- Reset released mid-game restarts everything from reset values on the next edge.

## Test plan
- Reset low → cars row0 at 0/120/240/360, FrogX=320, FrogY=440, lives=3, all flags 0. Release reset, one edge → row0 X=10/130/250/370; row1 base 633, so car0 X=633.
- Hold `up` high for 5 frames from reset → FrogY=400 after the first edge and stays 400. Press `left` at FrogX=0 → X stays 0.
- Place the frog in row0 (one `up`) and wait → `Car_Collision[0]`=1 once a car overlaps. Next edge: `dead_frog`=1 for one frame, frog at (320,440), lives=2.
- Three deaths → lives 3→2→1→0, `lose_game`=1. Further keys do not move the frog; cars keep moving.
- Step `up` 10 times, timed so no collision occurs (or with all speeds 0 and cars clear of X=320) → FrogY reaches 40, `win_game`=1 on that edge, frog frozen.
- `up` and `left` rise in the same frame → only the up move is taken. Collision pending plus key rise in the same frame → respawn, no move.
